input_queue: RTL



---
 rtl/input_queue_pkg.sv | 24 ++
 rtl/input_queue_ram_dual_port.sv | 31 +++
 rtl/input_queue.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/input_queue_pkg.sv
// Shared definitions for the trace input queue: pipeline latencies, the stored
// entry layout and a helper giving its packed width for any lane configuration.
package input_queue_pkg;

    localparam int LATENCY     = 2;
    localparam int RAM_LATENCY = 1;

    localparam int N_DEF          = 8;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int CHAIN_W_DEF    = 1;

    // Entry layout for the default configuration; the queue packs the same
    // {eof, chain, vector} ordering for any parameter set.
    typedef struct packed {
        logic                                eof;
        logic [CHAIN_W_DEF-1:0]              chain;
        logic [N_DEF*DATA_WIDTH_DEF-1:0]     vector;
    } entry_t;

    function automatic int entry_width(input int n, input int dw, input int cw);
        return n * dw + cw + 1;
    endfunction

endpackage

// File: rtl/input_queue_ram_dual_port.sv
// Simple dual-port RAM: port A write-only, port B read-only with a registered
// read data output (one cycle of latency). Contents are undefined after reset.
module ram_dual_port #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/input_queue.sv
// Circular vector queue with per-entry EOF/chain side-band, fixed two-cycle
// read delivery, configurable almost-full threshold and overflow accounting.
module input_queue
    import input_queue_pkg::*;
#(
    parameter int         N          = 8,
    parameter int         DATA_WIDTH = 32,
    parameter int         IB_DEPTH   = 4,
    parameter int         CHAIN_W    = 1,
    parameter logic [7:0] CFG_ID     = 8'd1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enqueue,
    input  logic                          eof_in,
    input  logic [CHAIN_W-1:0]            chain_in,
    input  logic                          tracing,
    input  logic [7:0]                    configId,
    input  logic [7:0]                    configData,
    input  logic [DATA_WIDTH-1:0]         vector_in [N-1:0],
    input  logic                          ready_in,
    output logic                          valid_out,
    output logic                          eof_out,
    output logic [CHAIN_W-1:0]            chainId_out,
    output logic [DATA_WIDTH-1:0]         vector_out [N-1:0],
    output logic [$clog2(IB_DEPTH+1)-1:0] count,
    output logic                          almost_full,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    localparam int CW = $clog2(IB_DEPTH + 1);
    localparam int PW = $clog2(IB_DEPTH);
    localparam int EW = entry_width(N, DATA_WIDTH, CHAIN_W);
    localparam int VW = N * DATA_WIDTH;

    localparam logic [CW-1:0] DEPTH_C  = CW'(IB_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(IB_DEPTH - 1);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_nxt, afull_thr, thr_nxt;
    logic          wr_ok, rd_ok, drop;
    logic          rd_pend;
    logic [VW-1:0] vec_flat;
    logic [EW-1:0] wr_word, rd_word;

    // Fullness uses the registered count only, so a same-cycle read never
    // frees a slot for the write, and a write into an empty queue is not readable yet.
    assign wr_ok = enqueue & tracing & (count < DEPTH_C);
    assign drop  = enqueue & tracing & (count == DEPTH_C);
    assign rd_ok = ready_in & (count != '0);

    always_comb begin
        vec_flat = '0;
        for (int i = 0; i < N; i++) begin
            vec_flat[i*DATA_WIDTH +: DATA_WIDTH] = vector_in[i];
        end
    end

    assign wr_word = {eof_in, chain_in, vec_flat};

    ram_dual_port #(
        .WIDTH (EW),
        .DEPTH (IB_DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (wr_word),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        thr_nxt = afull_thr;
        if (configId == CFG_ID) begin
            thr_nxt = (32'(configData) > IB_DEPTH) ? DEPTH_C : CW'(configData);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            afull_thr   <= CW'(IB_DEPTH - 1);
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end
            count       <= count_nxt;
            afull_thr   <= thr_nxt;
            almost_full <= (count_nxt >= thr_nxt);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    // rd_pend tracks the RAM read in flight; the output register captures it
    // one cycle later, giving valid_out two cycles after the read is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend     <= 1'b0;
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
            chainId_out <= '0;
            for (int i = 0; i < N; i++) begin
                vector_out[i] <= '0;
            end
        end else begin
            rd_pend   <= rd_ok;
            valid_out <= rd_pend;
            if (rd_pend) begin
                eof_out     <= rd_word[EW-1];
                chainId_out <= rd_word[VW +: CHAIN_W];
                for (int i = 0; i < N; i++) begin
                    vector_out[i] <= rd_word[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule
